apb_regfile_slave: RTL

APB completer (slave) that terminates one select line driven by the APB bridge and exposes a small bank of 32-bit control/status registers. It decodes setup/access phases, inserts a programmable number of wait states, performs the register read or write, and signals completion with Pready and errors with Pslverr. It is the responder-side counterpart of the bridge FSM and plugs directly onto its Pselx/Penable/Pwrite/Paddr/Pwdata outputs.

---
 rtl/apb_regfile_slave.sv | 97 +++++++++
 1 files changed

// File: rtl/apb_regfile_slave.sv
// APB completer exposing eight 32-bit registers (R0 = read-only ID, R1..R7 = read/write)
// with a fixed number of access-phase wait states and Pslverr on bad decodes.
module apb_regfile_slave #(
   parameter int unsigned SLAVE_IDX   = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Pready,
   output logic        Pslverr
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic [2:0]  lat_idx;
   logic        lat_write;
   logic        lat_valid;
   logic [31:0] lat_wdata;
   logic [31:0] regs [1:7];

   logic        sel;
   logic [2:0]  idx;
   logic        dec_valid;
   logic [31:0] rd_value;
   logic        setup;
   logic        access_on;

   // Mask-and-reduce keeps every select bit referenced while picking ours.
   assign sel       = |(Pselx & (3'b001 << SLAVE_IDX));
   assign idx       = Paddr[4:2];
   assign dec_valid = (Paddr[31:5] == BASE_ADDR[31:5]) && (Paddr[1:0] == 2'b00)
                      && !(Pwrite && (idx == 3'd0));
   assign setup     = (state == IDLE) && sel && !Penable;
   assign access_on = (state == ACCESS) && sel && Penable;

   assign Pready  = (state == ACCESS) && (cnt == 3'd0);
   assign Pslverr = Pready && !lat_valid;

   always_comb begin
      rd_value = ID_VALUE;
      for (int unsigned i = 1; i < 8; i++) begin
         if (idx == 3'(i)) rd_value = regs[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel && !Penable) state_nxt = ACCESS;
         ACCESS:  if (!sel || !Penable || (cnt == 3'd0)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         Prdata    <= '0;
         lat_idx   <= '0;
         lat_write <= 1'b0;
         lat_valid <= 1'b0;
         lat_wdata <= '0;
         for (int unsigned i = 1; i < 8; i++) regs[i] <= '0;
      end else if (setup) begin
         lat_idx   <= idx;
         lat_write <= Pwrite;
         lat_wdata <= Pwdata;
         lat_valid <= dec_valid;
         cnt       <= 3'(WAIT_CYCLES);
         Prdata    <= (dec_valid && !Pwrite) ? rd_value : '0;
      end else if (access_on) begin
         if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end else if (lat_valid && lat_write) begin
            for (int unsigned i = 1; i < 8; i++) begin
               if (lat_idx == 3'(i)) regs[i] <= lat_wdata;
            end
         end
      end
   end

endmodule
